// File: rtl/lab2_proc_fetch_drop_filter_pkg.sv
// Shared definitions for the fetch-stage drop filter.
// Holds the inflight-counter width macro, the imem message width constants
// and the response-path mode type.
`ifndef LAB2_PROC_FETCH_CNT_NBITS
`define LAB2_PROC_FETCH_CNT_NBITS(n) $clog2((n)+1)
`endif

package lab2_proc_fetch_drop_filter_pkg;

    // Widths of mem_req_4B_t / mem_resp_4B_t as defined by the memory message library
    localparam int MEM_REQ_4B_NBITS  = 77;
    localparam int MEM_RESP_4B_NBITS = 47;

    // Response path either forwards to the F stage or swallows stale responses
    typedef enum logic {
        RESP_PASS    = 1'b0,
        RESP_DISCARD = 1'b1
    } resp_mode_e;

endpackage

// File: rtl/lab2_proc_fetch_drop_filter_counter.sv
// Up/down counter with a synchronous load, asynchronous active-high reset.
// Used for the inflight count and for the drop snapshot counter.
module lab2_proc_UpDownCounter #(
    parameter int p_nbits = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               incr,
    input  logic               decr,
    input  logic               load,
    input  logic [p_nbits-1:0] load_value,
    output logic [p_nbits-1:0] count
);

    logic [p_nbits-1:0] count_reg;
    logic [p_nbits-1:0] count_next;

    // Load takes priority; otherwise simultaneous incr and decr cancel out
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else begin
            count_next = count_reg + p_nbits'(incr) - p_nbits'(decr);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/lab2_proc_fetch_drop_filter.sv
// Fetch-stage imem request/response tracker with squash filtering.
// Tracks up to p_max_inflight outstanding fetches, back-pressures the request
// side when full, and discards responses that belong to squashed fetches.
// Optional feature macro: LAB2_PROC_FETCH_DROP_STATS_EN enables the 32-bit
// num_dropped counter; without it num_dropped reads as zero.
module lab2_proc_fetch_drop_filter
    import lab2_proc_fetch_drop_filter_pkg::*;
#(
    parameter int p_req_nbits    = MEM_REQ_4B_NBITS,
    parameter int p_resp_nbits   = MEM_RESP_4B_NBITS,
    parameter int p_max_inflight = 2,
    parameter int p_cnt_nbits    = `LAB2_PROC_FETCH_CNT_NBITS(p_max_inflight)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    drop,
    input  logic [p_req_nbits-1:0]  req_in_msg,
    input  logic                    req_in_val,
    output logic                    req_in_rdy,
    output logic [p_req_nbits-1:0]  req_out_msg,
    output logic                    req_out_val,
    input  logic                    req_out_rdy,
    input  logic [p_resp_nbits-1:0] istream_msg,
    input  logic                    istream_val,
    output logic                    istream_rdy,
    output logic [p_resp_nbits-1:0] ostream_msg,
    output logic                    ostream_val,
    input  logic                    ostream_rdy,
    output logic [p_cnt_nbits-1:0]  num_inflight,
    output logic [31:0]             num_dropped
);

    localparam logic [p_cnt_nbits-1:0] MAX_CNT = p_cnt_nbits'(p_max_inflight);

    logic [p_cnt_nbits-1:0] inflight;
    logic [p_cnt_nbits-1:0] drop_cnt;
    logic                   full;
    logic                   req_fire;
    logic                   resp_fire;
    logic                   drop_cnt_decr;
    resp_mode_e             resp_mode;

    // Full is derived from registered state only, so the request path never
    // depends on the response handshake.
    assign full = (inflight == MAX_CNT);

    // Request path: zero-latency pass-through gated by the inflight limit
    always_comb begin
        req_out_msg = req_in_msg;
        req_out_val = req_in_val && !full;
        req_in_rdy  = req_out_rdy && !full;
    end

    assign req_fire = req_out_val && req_out_rdy;

    // Any pending squashed response, or a squash this very cycle, puts the
    // response path into discard mode.
    assign resp_mode = (drop || (drop_cnt != '0)) ? RESP_DISCARD : RESP_PASS;

    // Response path: forward to F stage, or accept-and-swallow when discarding
    always_comb begin
        ostream_msg = istream_msg;
        ostream_val = istream_val;
        istream_rdy = ostream_rdy;
        if (resp_mode == RESP_DISCARD) begin
            ostream_val = 1'b0;
            istream_rdy = 1'b1;
        end
    end

    assign resp_fire = istream_val && istream_rdy;

    lab2_proc_UpDownCounter #(
        .p_nbits (p_cnt_nbits)
    ) u_inflight_cnt (
        .clk        (clk),
        .reset      (reset),
        .incr       (req_fire),
        .decr       (resp_fire),
        .load       (1'b0),
        .load_value ('0),
        .count      (inflight)
    );

    // On a squash, every fetch still outstanding after this cycle's response
    // (if any) is stale. A request issued in the squash cycle is the redirect
    // target, so it is not counted. Re-squashing re-snapshots, never adds.
    assign drop_cnt_decr = (drop_cnt != '0) && istream_val;

    lab2_proc_UpDownCounter #(
        .p_nbits (p_cnt_nbits)
    ) u_drop_cnt (
        .clk        (clk),
        .reset      (reset),
        .incr       (1'b0),
        .decr       (drop_cnt_decr),
        .load       (drop),
        .load_value (inflight - p_cnt_nbits'(resp_fire)),
        .count      (drop_cnt)
    );

    assign num_inflight = inflight;

`ifdef LAB2_PROC_FETCH_DROP_STATS_EN
    logic        discard_fire;
    logic [31:0] num_dropped_reg;

    assign discard_fire = resp_fire && (resp_mode == RESP_DISCARD);

    // Count swallowed responses; wraps naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_dropped_reg <= '0;
        end else if (discard_fire) begin
            num_dropped_reg <= num_dropped_reg + 32'd1;
        end
    end

    assign num_dropped = num_dropped_reg;
`else
    assign num_dropped = 32'd0;
`endif

`ifndef SYNTHESIS
    // Protocol sanity: no orphan responses, never issue past the limit
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(istream_val && (inflight == '0)))
                else $error("response arrived with no fetch outstanding");
            assert (!(req_fire && full))
                else $error("request fired while inflight limit reached");
        end
    end
`endif

endmodule
